// File: rtl/alu_pkg.sv
// Shared encodings for the ALU family: operation select and the serial sequencer states.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_TEST = 3'd0,
      OP_PASS = 3'd1,
      OP_SUB  = 3'd2,
      OP_ADD  = 3'd3,
      OP_XOR  = 3'd4,
      OP_OR   = 3'd5,
      OP_NOT  = 3'd6,
      OP_AND  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_serial_if.sv
// Request/result handshake bundle of the bit-serial ALU.
interface alu_serial_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, carry, zero
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, carry, zero
   );
endinterface

// File: rtl/alu1.sv
// One-bit ALU slice: combines one bit of each operand with the incoming carry/borrow.
module alu1
   import alu_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   input  op_e  op,
   output logic out,
   output logic cout
);

   // Per-op bit function; logic ops report a constant 1 flag, TEST/PASS report 0.
   always_comb begin
      out  = 1'b0;
      cout = 1'b0;
      case (op)
         OP_TEST: begin out = ~(a ^ b);     cout = 1'b0; end
         OP_PASS: begin out = a;            cout = 1'b0; end
         OP_SUB:  begin
            out  = a ^ b ^ cin;
            cout = (~a & b) | (~(a ^ b) & cin);
         end
         OP_ADD:  begin
            out  = a ^ b ^ cin;
            cout = (a & b) | (a & cin) | (b & cin);
         end
         OP_XOR:  begin out = a ^ b;        cout = 1'b1; end
         OP_OR:   begin out = a | b;        cout = 1'b1; end
         OP_NOT:  begin out = ~a;           cout = 1'b1; end
         OP_AND:  begin out = a & b;        cout = 1'b1; end
         default: begin out = 1'b0;         cout = 1'b0; end
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: feeds one alu1 slice LSB first, one bit per clock, and
// assembles the result by shifting slice outputs in from the MSB side.
module alu_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   alu_serial_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   op_e              op_q;
   logic             cy_q;
   logic [CNT_W-1:0] cnt_q;
   logic             slice_out, slice_cout;
   logic             accept;

   alu1 u_slice (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (cy_q),
      .op   (op_q),
      .out  (slice_out),
      .cout (slice_cout)
   );

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and handshake outputs; requests are only seen in IDLE, so a
   // request arriving with the consuming edge waits for the following cycle.
   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt_q == LAST_BIT) state_d = ST_DONE;
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand capture on accept, then one slice step per RUN cycle; nothing moves in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= OP_TEST;
         res_q <= '0;
         cy_q  <= 1'b0;
         cnt_q <= '0;
      end else if (accept) begin
         a_q   <= bus.a;
         b_q   <= bus.b;
         op_q  <= op_e'(bus.op);
         cy_q  <= 1'b0;
         cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
         a_q   <= a_q >> 1;
         b_q   <= b_q >> 1;
         res_q <= {slice_out, res_q[WIDTH-1:1]};
         cy_q  <= slice_cout;
         cnt_q <= (cnt_q == LAST_BIT) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   assign bus.result = res_q;
   assign bus.carry  = cy_q;
   assign bus.zero   = (res_q == '0);

endmodule

// File: tb/tb_alu_serial.sv
// Directed and randomized checks of the bit-serial ALU against hand values and a word-level model.
module tb_alu_serial;
   localparam int W = 4;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   alu_serial_if #(.WIDTH(W)) bus_if ();

   alu_serial #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] ref_alu(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] s;
      case (o)
         3'd0: s = {1'b0, ~(x ^ y)};
         3'd1: s = {1'b0, x};
         3'd2: begin s[W-1:0] = x - y; s[W] = (x < y); end
         3'd3: s = {1'b0, x} + {1'b0, y};
         3'd4: s = {1'b1, x ^ y};
         3'd5: s = {1'b1, x | y};
         3'd6: s = {1'b1, ~x};
         default: s = {1'b1, x & y};
      endcase
      return s;
   endfunction

   // Presents one request while IDLE; returns at the falling edge after the accepting edge.
   task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.op       = o;
      bus_if.a        = x;
      bus_if.b        = y;
      @(posedge clk);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      bus_if.a        = W'($urandom);
      bus_if.b        = W'($urandom);
      bus_if.op       = 3'($urandom);
   endtask

   // Counts edges (accepting edge = 1) until out_valid is seen, bounded.
   task automatic wait_done(input string tag, output int lat);
      lat = 1;
      while (!bus_if.out_valid && lat < 4 * W + 8) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check({tag, "_done_seen"}, 32'(bus_if.out_valid), 32'd1);
   endtask

   task automatic consume(input string tag);
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      check({tag, "_ovld_after"}, 32'(bus_if.out_valid), 32'd0);
      check({tag, "_rdy_after"}, 32'(bus_if.in_ready), 32'd1);
   endtask

   task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er, input logic ec);
      int lat;
      start_op(o, x, y);
      wait_done(tag, lat);
      check({tag, "_lat"}, 32'(lat), 32'(W + 1));
      check({tag, "_res"}, 32'(bus_if.result), 32'(er));
      check({tag, "_cy"}, 32'(bus_if.carry), 32'(ec));
      check({tag, "_zero"}, 32'(bus_if.zero), 32'(er == '0));
      check({tag, "_inrdy"}, 32'(bus_if.in_ready), 32'd0);
      consume(tag);
   endtask

   initial begin
      int lat;
      int stall;
      logic quiet;
      logic [W:0] e;
      logic [2:0] ro;
      logic [W-1:0] ra, rb;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b0;
      bus_if.a  = '0;
      bus_if.b  = '0;
      bus_if.op = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_inrdy", 32'(bus_if.in_ready), 32'd1);
      check("rst_ovld", 32'(bus_if.out_valid), 32'd0);
      check("rst_res", 32'(bus_if.result), 32'd0);
      check("rst_cy", 32'(bus_if.carry), 32'd0);
      check("rst_zero", 32'(bus_if.zero), 32'd1);

      // Directed vectors, hand-computed for WIDTH=4.
      do_op("add_9_8",  3'd3, 4'h9, 4'h8, 4'h1, 1'b1);
      do_op("sub_3_5",  3'd2, 4'h3, 4'h5, 4'hE, 1'b1);
      do_op("sub_5_5",  3'd2, 4'h5, 4'h5, 4'h0, 1'b0);
      do_op("test_a_a", 3'd0, 4'hA, 4'hA, 4'hF, 1'b0);
      do_op("and_c_a",  3'd7, 4'hC, 4'hA, 4'h8, 1'b1);
      do_op("pass_6",   3'd1, 4'h6, 4'h9, 4'h6, 1'b0);
      do_op("not_5",    3'd6, 4'h5, 4'h0, 4'hA, 1'b1);
      do_op("or_5_a",   3'd5, 4'h5, 4'hA, 4'hF, 1'b1);
      do_op("xor_6_3",  3'd4, 4'h6, 4'h3, 4'h5, 1'b1);
      do_op("add_f_f",  3'd3, 4'hF, 4'hF, 4'hE, 1'b1);
      do_op("sub_0_1",  3'd2, 4'h0, 4'h1, 4'hF, 1'b1);

      // Hold in DONE with requests pulsed; outputs must not move.
      start_op(3'd3, 4'h7, 4'h3);
      wait_done("hold", lat);
      for (int i = 0; i < 10; i++) begin
         check("hold_res", 32'(bus_if.result), 32'hA);
         check("hold_cy", 32'(bus_if.carry), 32'd0);
         check("hold_ovld", 32'(bus_if.out_valid), 32'd1);
         check("hold_inrdy", 32'(bus_if.in_ready), 32'd0);
         bus_if.in_valid = (i % 2 == 0);
         bus_if.a  = 4'hF;
         bus_if.b  = 4'hF;
         bus_if.op = 3'd7;
         @(posedge clk);
         @(negedge clk);
      end
      bus_if.in_valid = 1'b0;
      check("hold_res_end", 32'(bus_if.result), 32'hA);
      // Consume and request in the same cycle: the request must wait one cycle.
      bus_if.out_ready = 1'b1;
      bus_if.in_valid  = 1'b1;
      bus_if.a  = 4'h2;
      bus_if.b  = 4'h3;
      bus_if.op = 3'd3;
      @(posedge clk);
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      check("noacc_inrdy", 32'(bus_if.in_ready), 32'd1);
      check("noacc_ovld", 32'(bus_if.out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      check("next_inrdy", 32'(bus_if.in_ready), 32'd0);
      wait_done("next", lat);
      check("next_lat", 32'(lat), 32'(W + 1));
      check("next_res", 32'(bus_if.result), 32'h5);
      check("next_cy", 32'(bus_if.carry), 32'd0);
      consume("next");

      // Reset during RUN at bit 2 aborts the operation.
      start_op(3'd3, 4'h9, 4'h8);
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus_if.out_ready = 1'b0;
      check("abort_inrdy", 32'(bus_if.in_ready), 32'd1);
      check("abort_ovld", 32'(bus_if.out_valid), 32'd0);
      check("abort_res", 32'(bus_if.result), 32'd0);
      check("abort_cy", 32'(bus_if.carry), 32'd0);
      check("abort_zero", 32'(bus_if.zero), 32'd1);
      quiet = 1'b1;
      for (int i = 0; i < 2 * W; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus_if.out_valid) quiet = 1'b0;
      end
      check("abort_no_result", 32'(quiet), 32'd1);
      do_op("add_7_1", 3'd3, 4'h7, 4'h1, 4'h8, 1'b0);

      // Random ops with random back-pressure in DONE.
      for (int k = 0; k < 40; k++) begin
         ro = 3'($urandom_range(0, 7));
         ra = W'($urandom);
         rb = W'($urandom);
         e  = ref_alu(ro, ra, rb);
         start_op(ro, ra, rb);
         wait_done("rnd", lat);
         check("rnd_lat", 32'(lat), 32'(W + 1));
         stall = $urandom_range(0, 4);
         for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
         end
         check("rnd_ovld", 32'(bus_if.out_valid), 32'd1);
         check("rnd_res", 32'(bus_if.result), 32'(e[W-1:0]));
         check("rnd_cy", 32'(bus_if.carry), 32'(e[W]));
         check("rnd_zero", 32'(bus_if.zero), 32'(e[W-1:0] == '0));
         consume("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
